adpll_loop_ctrl: RTL
====================

// Module: adpll_loop_ctrl
// PURPOSE
//  Parametrised digital loop controller for the ADPLL. It sits between the TDC/ACS
//  error path and the DCO.
//  - Holds a programmable parameter bank.
//  - Runs a saturating PI filter on the sign-magnitude phase error.
//  - Drives the DCO control code.
//  - Detects lock.
//  - Gives selectable debug readout on dout/sign.
//  Generalises the fixed 5-bit loop to any width W and adds lock detection.
// PARAMETERS
//  W         5   error magnitude / pgm_value / dout width
//  ACC_W     W+5 integrator width (signed)
//  NPARAM    8   parameter bank depth
//  SEL_W     3   param_sel width; NPARAM <= 2**SEL_W
//  LOCK_CNT  16  consecutive in-threshold samples needed to declare lock
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst          in   1      synchronous, active-high reset
//  clr          in   1      sync clear: parameter bank to defaults, integrator/lock to 0
//  pgm          in   1      level; its rising edge writes pgm_value into bank[param_sel]
//  param_sel    in   SEL_W  bank index for a write, and for readback (out_sel=3)
//  pgm_value    in   W      value to program
//  err_valid    in   1      one-cycle strobe: err_mag/err_sign are valid
//  err_mag      in   W      phase-error magnitude
//  err_sign     in   1      1 = negative error
//  out_sel      in   2      0 filter, 1 integral, 2 proportional, 3 bank[param_sel]
//  dco_ctrl     out  W      unsigned DCO code
//  dout         out  W      selected value, magnitude
//  sign         out  1      selected value, sign (0 when out_sel=3)
//  out_valid    out  1      pulses when filter outputs update
//  locked       out  1      lock indicator
// BEHAVIOUR
//  Parameter bank:
//  - Index 0 = KP, left shift, clamped to ACC_W-W-1. Index 1 = KI, right shift,
//    clamped to ACC_W-1. Index 2 = CENTRE (DCO free-run code). Index 3 = LOCK_TH.
//  - Indices 4..NPARAM-1 are spare, read/write only.
//  - Defaults: KP=1, KI=2, CENTRE=2**(W-1), LOCK_TH=1, spare=0.
//  - pgm edge detector is registered: the write lands 1 cycle after pgm rises.
//    Holding pgm high writes once. param_sel >= NPARAM: write ignored, readback 0.
//  Datapath (err_valid is the only trigger):
//  - S1 (cycle after err_valid): e = two's complement of {err_sign, err_mag}, W+1 bits;
//    -0 maps to 0. acc <= sat_ACC(acc + e). p <= e <<< KP.
//  - S2: f = sat_{W+1}(p + (acc >>> KI)).
//    dco_ctrl <= clamp(CENTRE + f, 0, 2**W-1). out_valid = 1 for one cycle.
//  - Latency err_valid -> dco_ctrl/out_valid = 2 cycles. Back-to-back err_valid is
//    fully pipelined, 1 sample/cycle.
//  - Saturation is symmetric: ±(2**(N-1)-1). Never wraps.
//  - Readout: out_sel picks f, acc >>> KI (saturated to W+1 bits), p (saturated) or the
//    bank entry, then converts to sign-magnitude. Readout is a registered mux:
//    out_sel/param_sel changes appear after 1 cycle.
//  Lock FSM (advances only on S1 samples), states IDLE, TRACK, LOCKED:
//  - IDLE -> TRACK on the first sample.
//  - TRACK: cnt++ if err_mag <= LOCK_TH, else cnt = 0. cnt == LOCK_CNT-1 with an
//    in-threshold sample -> LOCKED (locked=1).
//  - LOCKED: any sample with err_mag > LOCK_TH -> TRACK, cnt = 0, locked=0 the next cycle.
//  Reset/clear:
//  - rst: bank to defaults, acc/p/f/cnt = 0, FSM IDLE.
//    Outputs: dco_ctrl = 2**(W-1), dout = 0, sign = 0, out_valid = 0, locked = 0.
//  - clr: same as rst except the edge-detector history is kept.
//  - clr and pgm edge in the same cycle: clr wins, the write is dropped.
//  - rst or clr while a sample is in S1/S2: the sample is discarded, no out_valid.
// STRUCTURE
//  - Shared package adpll_pkg:
//    - parameter-index constants IDX_KP/IDX_KI/IDX_CENTRE/IDX_LOCK_TH
//    - lock FSM state enum
//    - sign-magnitude <-> two's complement functions
//    - generic saturate function
//  - One sub-module: adpll_param_bank (pgm edge detect, NPARAM x W registers,
//    clear/defaults, readback). The filter, lock FSM and readout stay in this module.
// TESTING
//  - Reset defaults: after rst, dco_ctrl=16, locked=0, dout=0.
//    out_sel=3, param_sel=2 -> dout=16, sign=0 (W=5).
//  - Programming: pgm rises with param_sel=0, pgm_value=3 and is held 5 cycles ->
//    single write, readback 3. Same cycle with clr=1 -> readback 1.
//  - Step: defaults, one sample err=+4 ->
//    S1 acc=4, p=8; S2 f = 8 + (4>>>2) = 9, dco_ctrl=25, out_valid 2 cycles after
//    err_valid. A second +4 gives f = 8 + 2 = 10, dco_ctrl=26.
//  - Saturation: continuous err=+31 for 2000 cycles ->
//    acc stops at 2**(ACC_W-1)-1, dco_ctrl stays at 31, no wrap. Then err=-31 ->
//    acc decreases monotonically.
//  - Lock: 16 samples with |err|<=1 -> locked=1 after the 16th S1.
//    One err=5 -> locked=0 next cycle. 15 good samples then a bad one -> stays 0.
//  - rst asserted between err_valid and S2 -> no out_valid, dco_ctrl=16,
//    acc=0 on readback.

Source files
------------

// File: rtl/adpll_pkg.sv
// rtl/adpll_pkg.sv - shared constants, lock states and arithmetic helpers for the ADPLL loop
package adpll_pkg;

  localparam int IDX_KP      = 0;
  localparam int IDX_KI      = 1;
  localparam int IDX_CENTRE  = 2;
  localparam int IDX_LOCK_TH = 3;

  typedef enum logic [1:0] {
    LK_IDLE   = 2'd0,
    LK_TRACK  = 2'd1,
    LK_LOCKED = 2'd2
  } lock_state_t;

  // Wide scratch type so the helpers work for any loop width.
  typedef logic signed [63:0] wide_t;

  function automatic wide_t sm_to_tc(input logic neg, input logic [63:0] mag);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

  function automatic logic [63:0] tc_mag(input wide_t v);
    return v[63] ? -v : v;
  endfunction

  // Symmetric clamp to +/-(2**(n-1)-1).
  function automatic wide_t sat(input wide_t v, input int n);
    wide_t lim;
    lim = (wide_t'(1) <<< (n - 1)) - wide_t'(1);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/adpll_param_bank.sv
// rtl/adpll_param_bank.sv - programmable loop parameter bank with registered pgm edge detect
module adpll_param_bank
  import adpll_pkg::*;
#(
  parameter int W      = 5,
  parameter int NPARAM = 8,
  parameter int SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             pgm,
  input  logic [SEL_W-1:0] param_sel,
  input  logic [W-1:0]     pgm_value,
  output logic [W-1:0]     rd_data,
  output logic [W-1:0]     kp,
  output logic [W-1:0]     ki,
  output logic [W-1:0]     centre,
  output logic [W-1:0]     lock_th
);

  logic [W-1:0] bank [NPARAM];
  logic         pgm_q;
  logic         pgm_rise;
  logic         sel_ok;

  function automatic logic [W-1:0] dflt(input int i);
    if (i == IDX_KP)      return W'(1);
    if (i == IDX_KI)      return W'(2);
    if (i == IDX_CENTRE)  return W'(1 << (W - 1));
    if (i == IDX_LOCK_TH) return W'(1);
    return '0;
  endfunction

  assign pgm_rise = pgm & ~pgm_q;
  assign sel_ok   = 32'(param_sel) < NPARAM;

  // Edge history survives clr so a pgm held across a clear cannot re-fire.
  always_ff @(posedge clk) begin
    if (rst) pgm_q <= 1'b0;
    else     pgm_q <= pgm;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NPARAM; i++) bank[i] <= dflt(i);
    end else if (pgm_rise && sel_ok) begin
      bank[param_sel] <= pgm_value;
    end
  end

  assign rd_data = sel_ok ? bank[param_sel] : '0;
  assign kp      = bank[IDX_KP];
  assign ki      = bank[IDX_KI];
  assign centre  = bank[IDX_CENTRE];
  assign lock_th = bank[IDX_LOCK_TH];

endmodule

// File: rtl/adpll_loop_ctrl.sv
// rtl/adpll_loop_ctrl.sv - saturating PI loop filter, DCO drive, lock detect and debug readout
module adpll_loop_ctrl
  import adpll_pkg::*;
#(
  parameter int W        = 5,
  parameter int ACC_W    = W + 5,
  parameter int NPARAM   = 8,
  parameter int SEL_W    = 3,
  parameter int LOCK_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             pgm,
  input  logic [SEL_W-1:0] param_sel,
  input  logic [W-1:0]     pgm_value,
  input  logic             err_valid,
  input  logic [W-1:0]     err_mag,
  input  logic             err_sign,
  input  logic [1:0]       out_sel,
  output logic [W-1:0]     dco_ctrl,
  output logic [W-1:0]     dout,
  output logic             sign,
  output logic             out_valid,
  output logic             locked
);

  localparam int KP_MAX = ACC_W - W - 1;
  localparam int KI_MAX = ACC_W - 1;
  localparam int CNT_W  = $clog2(LOCK_CNT + 1);

  logic [W-1:0] kp_raw, ki_raw, centre, lock_th, bank_rd;

  adpll_param_bank #(.W(W), .NPARAM(NPARAM), .SEL_W(SEL_W)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .pgm       (pgm),
    .param_sel (param_sel),
    .pgm_value (pgm_value),
    .rd_data   (bank_rd),
    .kp        (kp_raw),
    .ki        (ki_raw),
    .centre    (centre),
    .lock_th   (lock_th)
  );

  logic signed [ACC_W-1:0] acc, p, acc_n, p_n;
  logic signed [W:0]       f, f_n;
  logic [W-1:0]            dco_n;
  logic                    s1_valid;
  int                      kp_sh, ki_sh;
  wide_t                   e_w, ai_w, dco_w, rd_v;

  always_comb begin
    kp_sh = (int'(kp_raw) > KP_MAX) ? KP_MAX : int'(kp_raw);
    ki_sh = (int'(ki_raw) > KI_MAX) ? KI_MAX : int'(ki_raw);
    e_w   = sm_to_tc(err_sign, 64'(err_mag));
    acc_n = ACC_W'(sat(64'(acc) + e_w, ACC_W));
    p_n   = ACC_W'(e_w <<< kp_sh);
    ai_w  = 64'(acc) >>> ki_sh;
    f_n   = (W+1)'(sat(64'(p) + ai_w, W + 1));
    dco_w = 64'($signed({1'b0, centre})) + 64'(f_n);
    if (dco_w[63])                              dco_n = '0;
    else if (dco_w > wide_t'((1 << W) - 1))     dco_n = '1;
    else                                        dco_n = W'(dco_w);
  end

  always_comb begin
    case (out_sel)
      2'd0:    rd_v = 64'(f);
      2'd1:    rd_v = sat(ai_w, W + 1);
      2'd2:    rd_v = sat(64'(p), W + 1);
      default: rd_v = 64'($signed({1'b0, bank_rd}));
    endcase
  end

  // S1 on err_valid updates acc/p; S2 one cycle later forms f and the DCO code.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc       <= '0;
      p         <= '0;
      f         <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      dco_ctrl  <= W'(1 << (W - 1));
      dout      <= '0;
      sign      <= 1'b0;
    end else begin
      s1_valid  <= err_valid;
      out_valid <= s1_valid;
      if (err_valid) begin
        acc <= acc_n;
        p   <= p_n;
      end
      if (s1_valid) begin
        f        <= f_n;
        dco_ctrl <= dco_n;
      end
      dout <= W'(tc_mag(rd_v));
      sign <= rd_v[63];
    end
  end

  lock_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             in_th;

  assign in_th = err_mag <= lock_th;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= LK_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // IDLE counts its first sample exactly like TRACK does.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (err_valid) begin
      case (state)
        LK_IDLE, LK_TRACK: begin
          if (!in_th) begin
            state_n = LK_TRACK;
            cnt_n   = '0;
          end else if (cnt == CNT_W'(LOCK_CNT - 1)) begin
            state_n = LK_LOCKED;
            cnt_n   = '0;
          end else begin
            state_n = LK_TRACK;
            cnt_n   = cnt + 1'b1;
          end
        end
        LK_LOCKED: begin
          if (!in_th) begin
            state_n = LK_TRACK;
            cnt_n   = '0;
          end
        end
        default: begin
          state_n = LK_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign locked = (state == LK_LOCKED);

endmodule
